fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined RV32 core; replaces the fixed PC register, PC+4 adder and combinational instruction-memory lookup of the single-cycle datapath.
- Issues pipelined requests to an instruction memory through a req/gnt/rvalid handshake that allows variable latency.
- Buffers returned instructions, with their PCs, in a DEPTH-entry ring and presents them to decode under valid/ready.
- On a redirect from EX (branch, JAL, JALR), flushes the ring and discards in-flight responses.

Parameters:
XLEN, 32, width of PC and instruction
DEPTH, 4, ring-buffer entries and max outstanding requests; power of 2, >=2
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  request valid
imem_addr  out  XLEN  byte address of requested word, bits[1:0]=0
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  XLEN  response instruction
inst_valid  out  1  head entry holds an instruction
inst  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction
inst_pc4  out  XLEN  inst_pc+4, modulo 2^XLEN
inst_ready  in  1  decode consumes head
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new fetch PC; bits[1:0] forced to 0
fetch_pc  out  XLEN  next PC to be requested (debug/ssd)
occupancy  out  clog2(DEPTH)+1  allocated entries, filled plus awaiting response

Behaviour:
- State: fetch_pc, alloc/fill/head pointers (clog2(DEPTH)+1 bits with wrap bit), pending counter, drop counter, and per-entry {pc, inst, filled}.
- Reset (async): fetch_pc=RESET_PC; pointers, pending and drop = 0; all filled=0; inst_valid=0; imem_req=0 while rst is high.
- Reset contract: the memory is reset by the same rst; no response to a pre-reset request may arrive after reset.
- Derived quantities:
  - occupancy = alloc-head.
  - pending = accepted requests whose response has not yet returned, including those to be dropped.
- Request issue:
  - imem_req = !rst && !redirect_valid && occupancy<DEPTH && pending<DEPTH.
  - imem_addr = fetch_pc.
- On imem_req && imem_gnt:
  - entry[alloc].pc = fetch_pc, filled=0, alloc++.
  - fetch_pc += 4, wrapping modulo 2^XLEN.
  - pending++.
- Responses:
  - The memory returns exactly one imem_rvalid per accepted request, in order, no earlier than the cycle after gnt.
  - Each rvalid decrements pending.
  - If drop>0: response discarded, drop--.
  - Else: entry[fill].inst=imem_rdata, filled=1, fill++.
- Output:
  - inst_valid = entry[head].filled; inst, inst_pc and inst_pc4 come from entry[head] and are registered state only, with no combinational path from imem_rdata.
  - Zero-wait memory therefore gives 2-cycle latency from request acceptance to inst_valid.
- Pop: inst_valid && inst_ready → filled=0, head++.
- Redirect cycle (redirect_valid=1):
  - No request issued; any pop is ignored.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - head, fill and alloc all set to the same value; all filled cleared.
  - drop <= pending after this cycle's rvalid is accounted for (drop = pending - rvalid). A same-cycle rvalid is consumed: it decrements drop if drop>0, otherwise it is discarded and its entry is not written.
  - Requests resume the following cycle, even while drop>0.
- Simultaneous events:
  - Accept, response and pop in the same cycle all update consistently.
  - occupancy = DEPTH blocks requests even if a pop happens this cycle; the pop frees space from the next cycle.
- Back-to-back redirects: each one recomputes drop from pending; the last one wins fetch_pc.
- Counter widths: clog2(DEPTH)+1 bits, which never overflow given the pending<DEPTH guard.
- Misaligned redirect_pc: low bits silently cleared; no exception raised.

Test Plan:
- Reset and first fetch:
  - Stimulus: rst pulse with gnt=1.
  - Required: first cycle after release, imem_req=1, imem_addr=0; inst_valid=0 until the first rvalid; fetch_pc=4 after the grant.
- Zero-wait streaming:
  - Stimulus: gnt=1, rvalid one cycle after each gnt with rdata=addr^32'hA5A5_0000, ready=1.
  - Required: from cycle 2 onward, one instruction per cycle with inst_pc=0,4,8,12,… and inst_pc4=inst_pc+4; no bubbles.
- Backpressure, DEPTH=4:
  - Stimulus: ready=0.
  - Required: exactly 4 grants (addr 0,4,8,12), then imem_req=0 and occupancy=4. After raising ready, pops occur in order 0,4,8,12 and imem_req re-asserts the cycle after the first pop.
- Redirect with 3 in flight:
  - Stimulus: rvalid latency 3; redirect_pc=0x100 while pending=3.
  - Required: the next 3 rvalids are dropped; the first inst_valid carries inst_pc=0x100 and the rdata of the 0x100 request; no stale PC ever appears.
- Redirect colliding with a response and a pop:
  - Stimulus: redirect_valid, imem_rvalid and inst_ready all high in the same cycle, with redirect_pc=0x203.
  - Required: occupancy=0 next cycle; fetch_pc=0x200; drop=pending-1.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges while occupancy=3.
  - Required: inst_valid=0, occupancy=0 and fetch_pc=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: pipelined imem requests into a DEPTH-entry
// ring of {pc, inst}, drained by decode under valid/ready, flushed on redirect.
module fetch_prefetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     inst_valid,
    output logic [XLEN-1:0]          inst,
    output logic [XLEN-1:0]          inst_pc,
    output logic [XLEN-1:0]          inst_pc4,
    input  logic                     inst_ready,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic [XLEN-1:0]          fetch_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [XLEN-1:0] fetchPc;
    logic [PW-1:0]   allocPtr;
    logic [PW-1:0]   fillPtr;
    logic [PW-1:0]   headPtr;
    logic [PW-1:0]   pendCnt;
    logic [PW-1:0]   dropCnt;
    logic [XLEN-1:0] entPc   [DEPTH];
    logic [XLEN-1:0] entInst [DEPTH];
    logic [DEPTH-1:0] entFilled;

    logic [IW-1:0] allocIdx;
    logic [IW-1:0] fillIdx;
    logic [IW-1:0] headIdx;
    logic          accept;
    logic          pop;
    logic          unusedBits;

    assign allocIdx  = allocPtr[IW-1:0];
    assign fillIdx   = fillPtr[IW-1:0];
    assign headIdx   = headPtr[IW-1:0];
    assign unusedBits = ^redirect_pc[1:0];

    assign occupancy = allocPtr - headPtr;
    assign imem_req  = !rst && !redirect_valid
                     && (occupancy < DEPTH_P) && (pendCnt < DEPTH_P);
    assign imem_addr = fetchPc;
    assign fetch_pc  = fetchPc;

    // Decode sees only ring state, never imem_rdata directly.
    assign inst_valid = entFilled[headIdx];
    assign inst       = entInst[headIdx];
    assign inst_pc    = entPc[headIdx];
    assign inst_pc4   = entPc[headIdx] + XLEN'(4);

    assign accept = imem_req && imem_gnt;
    assign pop    = inst_valid && inst_ready && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc   <= RESET_PC;
            allocPtr  <= '0;
            fillPtr   <= '0;
            headPtr   <= '0;
            pendCnt   <= '0;
            dropCnt   <= '0;
            entFilled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entPc[i]   <= '0;
                entInst[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Everything still in flight becomes stale and must be skipped.
            fetchPc   <= {redirect_pc[XLEN-1:2], 2'b00};
            allocPtr  <= '0;
            fillPtr   <= '0;
            headPtr   <= '0;
            entFilled <= '0;
            pendCnt   <= pendCnt - PW'(imem_rvalid);
            dropCnt   <= pendCnt - PW'(imem_rvalid);
        end else begin
            if (accept) begin
                entPc[allocIdx]     <= fetchPc;
                entFilled[allocIdx] <= 1'b0;
                allocPtr            <= allocPtr + PW'(1);
                fetchPc             <= fetchPc + XLEN'(4);
            end
            if (imem_rvalid) begin
                if (dropCnt != '0) begin
                    dropCnt <= dropCnt - PW'(1);
                end else begin
                    entInst[fillIdx]   <= imem_rdata;
                    entFilled[fillIdx] <= 1'b1;
                    fillPtr            <= fillPtr + PW'(1);
                end
            end
            if (pop) begin
                entFilled[headIdx] <= 1'b0;
                headPtr            <= headPtr + PW'(1);
            end
            pendCnt <= pendCnt + PW'(accept) - PW'(imem_rvalid);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: variable-latency in-order memory model plus
// a stream-level reference (expected PC sequence, counts since last flush).
module tb_fetch_prefetch_unit;

    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic [31:0]   inst_pc4;
    logic          inst_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] occupancy;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_pc(fetch_pc), .occupancy(occupancy)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    typedef struct {
        logic        ready;
        logic        gnt;
        logic        expReq;
        logic [31:0] expAddr;
        int          expOcc;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    resp_t memQ[$];
    vec_t  vecs[10];

    int nVec = 0;
    int nErr = 0;
    int cyc = 0;
    int lat = 1;
    int lastDue = 0;

    // Reference: counts since last reset/redirect and the expected streams.
    logic [31:0] mNextReq;
    logic [31:0] mHeadPc;
    int mAlloc, mFilled, mPop, mDrop;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nVec++;
        nErr++;
        $display("FAIL %s at cycle %0d: bound expired", name, cyc);
    endtask

    task automatic modelReset();
        mNextReq = RESET_PC;
        mHeadPc  = RESET_PC;
        mAlloc = 0; mFilled = 0; mPop = 0; mDrop = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        imem_gnt = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; imem_rvalid = 1'b0;
        memQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        rst = 1'b0;
        cyc = 0;
        lastDue = 0;
        modelReset();
    endtask

    task automatic step();
        logic acc, rv, popEv, red, expV, expReq;
        logic [31:0] addr, rpc;
        int due;
        rv = 1'b0;
        if (memQ.size() > 0) rv = (memQ[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata = rv ? (memQ[0].addr ^ KEY) : 32'h0;
        #1;
        chk("addr", imem_addr, mNextReq);
        chk("fetch_pc", fetch_pc, mNextReq);
        chk("occ", 32'(occupancy), 32'(mAlloc - mPop));
        expV = (mFilled > mPop);
        chk("valid", 32'(inst_valid), 32'(expV));
        if (expV) begin
            chk("inst_pc", inst_pc, mHeadPc);
            chk("inst", inst, mHeadPc ^ KEY);
            chk("inst_pc4", inst_pc4, mHeadPc + 32'd4);
        end
        expReq = !redirect_valid && ((mAlloc - mPop) < DEPTH)
               && (memQ.size() < DEPTH);
        chk("req", 32'(imem_req), 32'(expReq));
        acc = imem_req && imem_gnt;
        popEv = inst_valid && inst_ready && !redirect_valid;
        red = redirect_valid;
        addr = imem_addr;
        rpc = redirect_pc;
        @(posedge clk);
        cyc++;
        if (rv) void'(memQ.pop_front());
        if (acc) begin
            due = cyc + lat - 1;
            if (due < lastDue) due = lastDue;
            lastDue = due;
            memQ.push_back('{addr, due});
        end
        if (red) begin
            mNextReq = {rpc[31:2], 2'b00};
            mHeadPc = mNextReq;
            mAlloc = 0; mFilled = 0; mPop = 0;
            mDrop = memQ.size();
        end else begin
            if (acc) begin
                mAlloc++;
                mNextReq = mNextReq + 32'd4;
            end
            if (rv) begin
                if (mDrop > 0) mDrop--;
                else mFilled++;
            end
            if (popEv) begin
                mPop++;
                mHeadPc = mHeadPc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic waitFirst(input string name, input logic [31:0] pc);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (inst_valid) found = 1;
            else step();
        end
        if (found) begin
            chk({name, "_pc"}, inst_pc, pc);
            chk({name, "_inst"}, inst, pc ^ KEY);
        end else begin
            failNow(name);
        end
    endtask

    initial begin
        vecs[0] = '{0, 1, 1, 32'h00, 0, 0, 32'h0};
        vecs[1] = '{0, 1, 1, 32'h04, 1, 0, 32'h0};
        vecs[2] = '{0, 1, 1, 32'h08, 2, 1, 32'h0};
        vecs[3] = '{0, 1, 1, 32'h0C, 3, 1, 32'h0};
        vecs[4] = '{0, 1, 0, 32'h10, 4, 1, 32'h0};
        vecs[5] = '{1, 1, 0, 32'h10, 4, 1, 32'h0};
        vecs[6] = '{1, 1, 1, 32'h10, 3, 1, 32'h4};
        vecs[7] = '{1, 1, 1, 32'h14, 3, 1, 32'h8};
        vecs[8] = '{1, 1, 1, 32'h18, 3, 1, 32'hC};
        vecs[9] = '{1, 1, 1, 32'h1C, 3, 1, 32'h10};

        // Backpressure from reset with a zero-wait memory.
        doReset();
        lat = 1;
        foreach (vecs[k]) begin
            inst_ready = vecs[k].ready;
            imem_gnt = vecs[k].gnt;
            #1;
            chk("tbl_req", 32'(imem_req), 32'(vecs[k].expReq));
            chk("tbl_addr", imem_addr, vecs[k].expAddr);
            chk("tbl_fetch_pc", fetch_pc, vecs[k].expAddr);
            chk("tbl_occ", 32'(occupancy), 32'(vecs[k].expOcc));
            chk("tbl_valid", 32'(inst_valid), 32'(vecs[k].expValid));
            if (vecs[k].expValid) chk("tbl_pc", inst_pc, vecs[k].expPc);
            step();
        end

        // Zero-wait streaming: one instruction per cycle from cycle 2.
        doReset();
        lat = 1; imem_gnt = 1; inst_ready = 1;
        step(); step();
        for (int k = 0; k < 10; k++) begin
            chk("stream_valid", 32'(inst_valid), 32'd1);
            chk("stream_pc", inst_pc, 32'(4 * k));
            step();
        end

        // Redirect with three requests in flight.
        doReset();
        lat = 4; imem_gnt = 1; inst_ready = 1;
        step(); step(); step();
        chk("r3_occ", 32'(occupancy), 32'd3);
        redirect_valid = 1; redirect_pc = 32'h100;
        step();
        redirect_valid = 0; inst_ready = 0;
        waitFirst("r3_first", 32'h100);
        inst_ready = 1;
        repeat (12) step();

        // Redirect colliding with a response and a pop.
        doReset();
        lat = 2; imem_gnt = 1; inst_ready = 1;
        repeat (4) step();
        chk("col_pre_valid", 32'(inst_valid), 32'd1);
        chk("col_pre_occ", 32'(occupancy), 32'd3);
        redirect_valid = 1; redirect_pc = 32'h203;
        step();
        redirect_valid = 0; inst_ready = 0;
        chk("col_occ", 32'(occupancy), 32'd0);
        chk("col_fetch_pc", fetch_pc, 32'h200);
        chk("col_valid", 32'(inst_valid), 32'd0);
        waitFirst("col_first", 32'h200);

        // Asynchronous reset between edges.
        doReset();
        lat = 1; imem_gnt = 1; inst_ready = 0;
        repeat (3) step();
        chk("ar_pre_occ", 32'(occupancy), 32'd3);
        chk("ar_pre_valid", 32'(inst_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(inst_valid), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_fetch_pc", fetch_pc, RESET_PC);
        chk("ar_req", 32'(imem_req), 32'd0);

        // Randomised traffic against the stream-level reference.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            imem_gnt = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = (i == 20) || ($urandom_range(0, 24) == 0);
            redirect_pc = (i == 20) ? 32'hFFFF_FFF6 : $urandom;
            lat = $urandom_range(1, 4);
            step();
        end
        redirect_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
